// File: rtl/sdhci_sdma.sv
// SDHCI single-channel SDMA: moves 32-bit buffer words to/from system memory over OBI, pausing at buffer boundaries.
// Latency: 2 cycles per word with immediate gnt/rvalid, one OBI transaction outstanding; stalls on gnt, rvalid and buffer ready.
module sdhci_sdma #(
    parameter int AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 dir_read_i,
    input  logic [AddrWidth-1:0] sys_addr_i,
    input  logic [11:0]          block_size_i,
    input  logic [15:0]          block_count_i,
    input  logic [2:0]           boundary_i,
    input  logic                 resume_i,
    input  logic                 abort_i,
    input  logic                 buf_rd_ready_i,
    input  logic [31:0]          buf_rdata_i,
    output logic                 buf_rd_o,
    input  logic                 buf_wr_ready_i,
    output logic [31:0]          buf_wdata_o,
    output logic                 buf_wr_o,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_err_i,
    output logic                 busy_o,
    output logic                 dma_int_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [AddrWidth-1:0] cur_addr_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_BLK = 3'd1;
    localparam logic [2:0] XFER     = 3'd2;
    localparam logic [2:0] RESP     = 3'd3;
    localparam logic [2:0] PAUSE    = 3'd4;
    localparam logic [2:0] DRAIN    = 3'd5;

    logic [2:0]           state;
    logic                 dir_read;
    logic [9:0]           blk_words;
    logic [9:0]           words_left;
    logic [15:0]          blocks_left;
    logic [AddrWidth-1:0] cur_addr;
    logic [AddrWidth-1:0] bnd_mask;

    logic [AddrWidth-1:0] next_addr;
    logic                 blk_end;
    logic [15:0]          next_blocks;

    assign next_addr   = cur_addr + AddrWidth'(4);
    assign blk_end     = (words_left == 10'd1);
    assign next_blocks = blk_end ? blocks_left - 16'd1 : blocks_left;

    // OBI A channel is driven straight from state so reset drops the request at once.
    assign mem_req_o   = (state == XFER);
    assign mem_addr_o  = mem_req_o ? cur_addr : '0;
    assign mem_we_o    = mem_req_o & dir_read;
    assign mem_be_o    = mem_req_o ? 4'hF : 4'h0;
    assign mem_wdata_o = mem_we_o ? buf_rdata_i : 32'h0;
    assign buf_rd_o    = mem_we_o & mem_gnt_i;

    assign buf_wr_o    = (state == RESP) & mem_rvalid_i & ~mem_err_i & ~abort_i & ~dir_read;
    assign buf_wdata_o = buf_wr_o ? mem_rdata_i : 32'h0;

    assign busy_o      = (state != IDLE);
    assign cur_addr_o  = cur_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            dir_read    <= 1'b0;
            blk_words   <= '0;
            words_left  <= '0;
            blocks_left <= '0;
            cur_addr    <= '0;
            bnd_mask    <= '0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            dma_int_o   <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            error_o   <= 1'b0;
            dma_int_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        dir_read    <= dir_read_i;
                        blk_words   <= 10'(block_size_i >> 2);
                        words_left  <= 10'(block_size_i >> 2);
                        blocks_left <= block_count_i;
                        cur_addr    <= sys_addr_i;
                        bnd_mask    <= (AddrWidth'(4096) << boundary_i) - AddrWidth'(1);
                        if (block_count_i == 16'd0) begin
                            done_o <= 1'b1;
                        end else begin
                            state <= WAIT_BLK;
                        end
                    end
                end
                WAIT_BLK: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (dir_read ? buf_rd_ready_i : buf_wr_ready_i) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    // A granted request must still see its response before going idle.
                    if (mem_gnt_i) begin
                        state <= abort_i ? DRAIN : RESP;
                    end else if (abort_i) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    if (abort_i) begin
                        // Response arriving with the abort is discarded like a drained one.
                        state <= mem_rvalid_i ? IDLE : DRAIN;
                    end else if (mem_rvalid_i) begin
                        if (mem_err_i) begin
                            error_o <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cur_addr    <= next_addr;
                            words_left  <= blk_end ? blk_words : words_left - 10'd1;
                            blocks_left <= next_blocks;
                            if (blk_end && next_blocks == 16'd0) begin
                                done_o <= 1'b1;
                                state  <= IDLE;
                            end else if ((next_addr & bnd_mask) == '0) begin
                                dma_int_o <= 1'b1;
                                state     <= PAUSE;
                            end else begin
                                state <= blk_end ? WAIT_BLK : XFER;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (resume_i) begin
                        cur_addr <= sys_addr_i;
                        state    <= (words_left == blk_words) ? WAIT_BLK : XFER;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdhci_sdma.sv
// Scoreboard bench for sdhci_sdma: stimulus queues expected OBI/buffer/event traffic, a monitor checks it.
module tb_sdhci_sdma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        dir_read_i = 1'b0;
    logic [31:0] sys_addr_i = '0;
    logic [11:0] block_size_i = '0;
    logic [15:0] block_count_i = '0;
    logic [2:0]  boundary_i = '0;
    logic        resume_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        buf_rd_ready_i = 1'b0;
    logic [31:0] buf_rdata_i;
    logic        buf_rd_o;
    logic        buf_wr_ready_i = 1'b0;
    logic [31:0] buf_wdata_o;
    logic        buf_wr_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;
    logic        busy_o;
    logic        dma_int_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] cur_addr_o;

    sdhci_sdma #(.AddrWidth(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .dir_read_i(dir_read_i),
        .sys_addr_i(sys_addr_i), .block_size_i(block_size_i), .block_count_i(block_count_i),
        .boundary_i(boundary_i), .resume_i(resume_i), .abort_i(abort_i),
        .buf_rd_ready_i(buf_rd_ready_i), .buf_rdata_i(buf_rdata_i), .buf_rd_o(buf_rd_o),
        .buf_wr_ready_i(buf_wr_ready_i), .buf_wdata_o(buf_wdata_o), .buf_wr_o(buf_wr_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o), .dma_int_o(dma_int_o), .done_o(done_o), .error_o(error_o),
        .cur_addr_o(cur_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } obi_t;

    localparam logic [2:0] EV_DONE = 3'b001;
    localparam logic [2:0] EV_INT  = 3'b010;
    localparam logic [2:0] EV_ERR  = 3'b100;

    obi_t        exp_obi[$];
    logic [31:0] exp_bufw[$];
    logic [2:0]  exp_evt[$];

    int n_checks = 0;
    int n_fail   = 0;

    // memory responder and buffer model state
    bit          gnt_rand = 0;
    int          gnt_wait = 0;
    int          rv_delay = 0;
    int          err_at   = -1;
    int          txn_cnt  = 0;
    bit          rv_pend  = 0;
    int          rv_wait  = 0;
    logic [31:0] rv_addr  = '0;
    bit          rv_err   = 0;
    int          buf_idx  = 0;
    bit          pop_pend = 0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;

    assign buf_rdata_i = 32'hB000_0000 + 32'(buf_idx);

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bad(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
    endtask

    // Memory side: inputs change on the falling edge, one transaction outstanding.
    always @(negedge clk) begin
        if (pop_pend) begin
            buf_idx++;
            pop_pend = 0;
        end
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = '0;
        mem_gnt_i    = 1'b0;
        if (rv_pend) begin
            if (rv_wait == 0) begin
                mem_rvalid_i = 1'b1;
                mem_err_i    = rv_err;
                mem_rdata_i  = rdata_of(rv_addr);
                rv_pend      = 0;
            end else begin
                rv_wait--;
            end
        end
        if (mem_req_o && !rv_pend) begin
            if (gnt_wait == 0) begin
                mem_gnt_i = 1'b1;
                rv_pend   = 1;
                rv_wait   = rv_delay;
                rv_addr   = mem_addr_o;
                rv_err    = (txn_cnt == err_at);
                txn_cnt++;
                gnt_wait  = gnt_rand ? int'($urandom_range(0, 3)) : 0;
            end else begin
                gnt_wait--;
            end
        end
    end

    obi_t        mon_e;
    logic [31:0] hold_addr = '0;
    logic        hold_we = 1'b0;
    bit          holding = 0;

    always @(negedge clk) begin
        #2;
        if (mem_req_o && holding) begin
            chk("addr_stable", mem_addr_o, hold_addr);
            chk("we_stable", mem_we_o, hold_we);
        end
        holding   = mem_req_o && !mem_gnt_i;
        hold_addr = mem_addr_o;
        hold_we   = mem_we_o;
        if (mem_req_o && mem_gnt_i) begin
            if (exp_obi.size() == 0) begin
                bad("obi_unexpected", mem_addr_o);
            end else begin
                mon_e = exp_obi.pop_front();
                chk("obi_addr", mem_addr_o, mon_e.addr);
                chk("obi_we", mem_we_o, mon_e.we);
                chk("obi_be", mem_be_o, 4'hF);
                if (mon_e.we) chk("obi_wdata", mem_wdata_o, mon_e.wdata);
            end
        end
        if (buf_rd_o) begin
            rd_pulses++;
            pop_pend = 1;
        end
        if (buf_wr_o) begin
            wr_pulses++;
            if (exp_bufw.size() == 0) bad("bufw_unexpected", buf_wdata_o);
            else chk("bufw_data", buf_wdata_o, exp_bufw.pop_front());
        end
        if (done_o || dma_int_o || error_o) begin
            if (exp_evt.size() == 0) bad("event_unexpected", {error_o, dma_int_o, done_o});
            else chk("event", {error_o, dma_int_o, done_o}, exp_evt.pop_front());
        end
    end

    task automatic start_xfer(input logic dir, input logic [31:0] addr, input logic [11:0] size,
                              input logic [15:0] count, input logic [2:0] bnd);
        dir_read_i    = dir;
        sys_addr_i    = addr;
        block_size_i  = size;
        block_count_i = count;
        boundary_i    = bnd;
        start_i       = 1'b1;
        @(negedge clk);
        start_i       = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) return;
            @(negedge clk);
        end
        bad({name, "_idle_timeout"}, 64'(busy_o));
    endtask

    task automatic wait_q(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_obi.size() == 0 && exp_bufw.size() == 0 && exp_evt.size() == 0) return;
            @(negedge clk);
        end
        bad({name, "_scoreboard_timeout"}, 64'(exp_obi.size() + exp_bufw.size() + exp_evt.size()));
    endtask

    task automatic end_test(input string name);
        repeat (3) @(negedge clk);
        chk({name, "_obi_left"}, 64'(exp_obi.size()), 64'd0);
        chk({name, "_bufw_left"}, 64'(exp_bufw.size()), 64'd0);
        chk({name, "_evt_left"}, 64'(exp_evt.size()), 64'd0);
        exp_obi.delete();
        exp_bufw.delete();
        exp_evt.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rd0;
        int wr0;
        obi_t e;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_mem_req", mem_req_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_be", mem_be_o, 4'h0);
        chk("rst_mem_we", mem_we_o, 1'b0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_buf_rd", buf_rd_o, 1'b0);
        chk("rst_buf_wr", buf_wr_o, 1'b0);
        chk("rst_buf_wdata", buf_wdata_o, 32'h0);
        chk("rst_events", {error_o, dma_int_o, done_o}, 3'b000);
        chk("rst_cur_addr", cur_addr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // single 512-byte block, card-to-memory
        buf_rd_ready_i = 1'b1;
        base = buf_idx;
        for (int k = 0; k < 128; k++) begin
            e.addr = 32'h1000 + 32'(4 * k); e.we = 1'b1; e.wdata = 32'hB000_0000 + 32'(base + k);
            exp_obi.push_back(e);
        end
        exp_evt.push_back(EV_DONE);
        rd0 = rd_pulses;
        start_xfer(1'b1, 32'h1000, 12'd512, 16'd1, 3'd7);
        chk("t1_busy_after_start", busy_o, 1'b1);
        wait_idle("t1", 600);
        wait_q("t1", 20);
        chk("t1_cur_addr", cur_addr_o, 32'h1200);
        chk("t1_busy", busy_o, 1'b0);
        chk("t1_rd_pulses", 64'(rd_pulses - rd0), 64'd128);
        end_test("t1");

        // mid-block boundary pause then resume at a new address
        base = buf_idx;
        e.we = 1'b1;
        e.addr = 32'h0FF8; e.wdata = 32'hB000_0000 + 32'(base);     exp_obi.push_back(e);
        e.addr = 32'h0FFC; e.wdata = 32'hB000_0000 + 32'(base + 1); exp_obi.push_back(e);
        exp_evt.push_back(EV_INT);
        start_xfer(1'b1, 32'h0FF8, 12'd16, 16'd1, 3'd0);
        wait_q("t2a", 50);
        chk("t2_pause_addr", cur_addr_o, 32'h1000);
        chk("t2_pause_busy", busy_o, 1'b1);
        e.addr = 32'h8000; e.wdata = 32'hB000_0000 + 32'(base + 2); exp_obi.push_back(e);
        e.addr = 32'h8004; e.wdata = 32'hB000_0000 + 32'(base + 3); exp_obi.push_back(e);
        exp_evt.push_back(EV_DONE);
        sys_addr_i = 32'h8000;
        resume_i   = 1'b1;
        @(negedge clk);
        resume_i   = 1'b0;
        chk("t2_resume_addr", cur_addr_o, 32'h8000);
        wait_idle("t2", 50);
        wait_q("t2b", 20);
        chk("t2_final_addr", cur_addr_o, 32'h8008);
        end_test("t2");

        // memory-to-card, 3 blocks of 8 bytes, random grant stalls, late buffer space
        buf_rd_ready_i = 1'b0;
        buf_wr_ready_i = 1'b0;
        gnt_rand = 1;
        gnt_wait = int'($urandom_range(0, 3));
        for (int k = 0; k < 6; k++) begin
            e.addr = 32'h2000 + 32'(4 * k); e.we = 1'b0; e.wdata = '0;
            exp_obi.push_back(e);
            exp_bufw.push_back(rdata_of(e.addr));
        end
        exp_evt.push_back(EV_DONE);
        wr0 = wr_pulses;
        start_xfer(1'b0, 32'h2000, 12'd8, 16'd3, 3'd7);
        for (int i = 0; i < 5; i++) begin
            chk("t3_wait_blk_hold", mem_req_o, 1'b0);
            @(negedge clk);
        end
        buf_wr_ready_i = 1'b1;
        wait_idle("t3", 200);
        wait_q("t3", 20);
        chk("t3_wr_pulses", 64'(wr_pulses - wr0), 64'd6);
        chk("t3_final_addr", cur_addr_o, 32'h2018);
        gnt_rand = 0;
        gnt_wait = 0;
        end_test("t3");

        // OBI error on the fifth word
        buf_rd_ready_i = 1'b1;
        txn_cnt = 0;
        err_at  = 4;
        base = buf_idx;
        for (int k = 0; k < 5; k++) begin
            e.addr = 32'h3000 + 32'(4 * k); e.we = 1'b1; e.wdata = 32'hB000_0000 + 32'(base + k);
            exp_obi.push_back(e);
        end
        exp_evt.push_back(EV_ERR);
        rd0 = rd_pulses;
        start_xfer(1'b1, 32'h3000, 12'd16, 16'd2, 3'd7);
        wait_idle("t4", 100);
        repeat (10) @(negedge clk);
        wait_q("t4", 20);
        chk("t4_rd_pulses", 64'(rd_pulses - rd0), 64'd5);
        chk("t4_busy", busy_o, 1'b0);
        err_at = -1;
        end_test("t4");

        // abort while waiting on a delayed response
        buf_rd_ready_i = 1'b0;
        buf_wr_ready_i = 1'b1;
        rv_delay = 4;
        e.addr = 32'h4000; e.we = 1'b0; e.wdata = '0;
        exp_obi.push_back(e);
        wr0 = wr_pulses;
        start_xfer(1'b0, 32'h4000, 12'd8, 16'd1, 3'd7);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                #1;
                if (mem_gnt_i) seen = 1;
            end
            if (!seen) bad("t5_grant_timeout", 64'(mem_req_o));
        end
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        @(negedge clk);
        chk("t5_drain_busy", busy_o, 1'b1);
        wait_idle("t5", 30);
        repeat (5) @(negedge clk);
        chk("t5_no_push", 64'(wr_pulses - wr0), 64'd0);
        chk("t5_busy", busy_o, 1'b0);
        rv_delay = 0;
        end_test("t5");

        // zero block count completes immediately
        exp_evt.push_back(EV_DONE);
        start_xfer(1'b1, 32'h5000, 12'd512, 16'd0, 3'd7);
        chk("t6_done_next_cycle", done_o, 1'b1);
        chk("t6_busy", busy_o, 1'b0);
        repeat (5) @(negedge clk);
        wait_q("t6", 10);
        end_test("t6");

        // abort and resume together while paused
        buf_rd_ready_i = 1'b1;
        base = buf_idx;
        e.we = 1'b1;
        e.addr = 32'h0FF8; e.wdata = 32'hB000_0000 + 32'(base);     exp_obi.push_back(e);
        e.addr = 32'h0FFC; e.wdata = 32'hB000_0000 + 32'(base + 1); exp_obi.push_back(e);
        exp_evt.push_back(EV_INT);
        start_xfer(1'b1, 32'h0FF8, 12'd16, 16'd1, 3'd0);
        wait_q("t7", 50);
        chk("t7_paused", busy_o, 1'b1);
        sys_addr_i = 32'h9000;
        abort_i    = 1'b1;
        resume_i   = 1'b1;
        @(negedge clk);
        abort_i    = 1'b0;
        resume_i   = 1'b0;
        chk("t7_idle", busy_o, 1'b0);
        chk("t7_addr_kept", cur_addr_o, 32'h1000);
        repeat (10) @(negedge clk);
        end_test("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdhci_sdma.md
# sdhci_sdma

Single-channel SDMA engine for the SDHCI controller. It moves block data between the controller's 32-bit buffer data port and system memory through an OBI manager port, so the host does not have to poll the buffer data register. It sits beside the register file and data-path wrapper: it consumes words from the buffer in card-to-memory transfers and produces them in memory-to-card transfers. It implements the SDHCI SDMA buffer-boundary pause/resume.

## Interface

- AddrWidth, 32, OBI address width and system address register width.
- clk_i  in  1  clock; every signal is synchronous to it.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  pulse; begins a transfer; ignored while busy_o=1.
- dir_read_i  in  1  1 = card-to-memory (OBI writes), 0 = memory-to-card (OBI reads); sampled on start.
- sys_addr_i  in  AddrWidth  start address; also the new address on resume; word aligned.
- block_size_i  in  12  bytes per block; multiple of 4, range 4..2048; sampled on start.
- block_count_i  in  16  number of blocks; sampled on start.
- boundary_i  in  3  SDMA buffer boundary size = 4 KiB << boundary_i; sampled on start.
- resume_i  in  1  pulse; continue after a boundary pause, loading sys_addr_i.
- abort_i  in  1  pulse; terminate the transfer.
- buf_rd_ready_i  in  1  a full block is readable; held until its last word is popped.
- buf_rdata_i  in  32  head word of the buffer; valid while buf_rd_ready_i=1.
- buf_rd_o  out  1  pop one word.
- buf_wr_ready_i  in  1  space for a full block is available.
- buf_wdata_o / buf_wr_o  out  32 / 1  word to push, and push strobe.
- mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  out  1, AddrWidth, 1, 4, 32  OBI A channel.
- mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i  in  1, 1, 32, 1  OBI grant and R channel.
- busy_o  out  1  a transfer is in progress, including a pause.
- dma_int_o, done_o, error_o  out  1 each  single-cycle event pulses.
- cur_addr_o  out  AddrWidth  current system address (SDMA system address readback).

## Operation

- States: IDLE, WAIT_BLK, XFER, RESP, PAUSE, DRAIN.
- IDLE, on start_i:
  - Latch the parameters, cur_addr = sys_addr_i, blocks_left = block_count_i, words_left = block_size_i/4.
  - If block_count_i = 0: pulse done_o and stay in IDLE.
  - Otherwise go to WAIT_BLK.
- WAIT_BLK: wait for buf_rd_ready_i (read direction) or buf_wr_ready_i (write direction), then go to XFER. Ready is not re-checked mid-block.
- XFER: mem_req_o = 1, mem_addr_o = cur_addr, mem_be_o = 4'hF, mem_we_o = dir_read.
  - In the read direction, mem_wdata_o = buf_rdata_i.
  - Address and data are held stable until mem_gnt_i.
  - On the grant cycle, in the read direction, buf_rd_o = 1. Then go to RESP.
- RESP: wait for mem_rvalid_i.
  - If mem_err_i = 1: pulse error_o and go to IDLE.
  - Otherwise, in the write direction, buf_wdata_o = mem_rdata_i and buf_wr_o = 1.
  - Then cur_addr += 4 (wraps modulo 2^AddrWidth) and words_left -= 1.
- After each word, the following checks apply in order:
  - Block finished (words_left = 0): blocks_left -= 1 and reload words_left.
  - Transfer finished (blocks_left = 0): pulse done_o and go to IDLE.
  - Boundary crossed ((cur_addr & (boundary_size-1)) = 0): pulse dma_int_o and go to PAUSE.
  - Otherwise go to WAIT_BLK if the block just finished, else XFER.
- PAUSE: on resume_i, load cur_addr = sys_addr_i and go to WAIT_BLK if at a block start, else XFER. A pause can fall mid-block.
- abort_i:
  - From WAIT_BLK, XFER before grant, or PAUSE: go to IDLE next cycle. No done_o and no error_o.
  - In RESP: go to DRAIN, which waits for mem_rvalid_i, discards it (no buffer push), then goes to IDLE.
  - A grant in the same cycle as abort_i completes to RESP first, then drains.
- Priority: abort_i > resume_i. start_i is ignored unless in IDLE. error_o and done_o never pulse together.
- busy_o = (state != IDLE).

## Timing

- Reset: state IDLE; every output 0, including cur_addr_o and mem_be_o.
- busy_o rises the cycle after start_i.
- Earliest mem_req_o is 2 cycles after start_i, when buffer ready is already high.
- One OBI transaction is outstanding at a time.
- With mem_gnt_i and mem_rvalid_i immediate, each word takes 2 cycles (XFER, RESP).
- done_o, dma_int_o and error_o are registered. Each pulses the cycle after the rvalid that completes its condition.
- cur_addr_o updates the cycle after each rvalid, and the cycle after resume_i.
- buf_rd_o and buf_wr_o are each exactly one cycle per word.
- Reset mid-transfer drops mem_req_o immediately. The memory side must be reset with this block.

## Test plan

- Single block, read direction: sys_addr 0x1000, size 512, count 1, boundary 7, immediate gnt/rvalid.
  - Expect 128 OBI writes at 0x1000..0x11FC, in order, with buffer words.
  - Expect 128 buf_rd_o pulses and one done_o.
  - Expect cur_addr_o = 0x1200 and busy_o low after done_o.
- Mid-block boundary pause: sys_addr 0x0FF8, size 16, count 1, boundary 0.
  - Expect 2 words, then dma_int_o and cur_addr_o = 0x1000.
  - Resume with 0x8000: expect words at 0x8000 and 0x8004, then done_o.
- Write direction with stalls: count 3, size 8, gnt delayed 0–3 random cycles.
  - Expect address and we stable until grant, and 6 buf_wr_o pulses carrying mem_rdata_i in order.
  - Expect WAIT_BLK to hold while buf_wr_ready_i = 0.
- OBI error: mem_err_i on word 5.
  - Expect error_o once, no done_o, IDLE, and no further requests.
- Abort in RESP with rvalid delayed 4 cycles.
  - Expect no new request, no buffer push, and IDLE after rvalid.
- block_count 0: expect done_o the cycle after start_i and no OBI request. Same-cycle abort_i + resume_i in PAUSE: expect IDLE.
